// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI receiver state encoding and default frame width
package spi_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WAIT_CS} spi_rx_state_t;
  localparam int SPI_WIDTH_DEFAULT = 12;
endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: serial pins from the master plus the received-word outputs
interface spi_slave_rx_if import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH_DEFAULT
) ();
  logic sclk;
  logic cs;
  logic mosi;
  logic [WIDTH-1:0] dout;
  logic done;
  logic err;
  logic busy;
  modport master (output sclk, cs, mosi, input dout, done, err, busy);
  modport slave (input sclk, cs, mosi, output dout, done, err, busy);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with one history flop for edge pulses
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES:0] sync_q;
  // Shift the pin through the synchroniser; the top bit is last cycle's level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {(SYNC_STAGES + 1){IDLE_LVL}};
    else sync_q <= {sync_q[SYNC_STAGES-1:0], d_i};
  end
  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  assign fall_o = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 SPI receiver deserialising one LSB-first word per chip-select frame
module spi_slave_rx import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  spi_slave_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  spi_rx_state_t state_q;
  logic run_q, done_q, err_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] shift_q, shift_d, dout_q;
  logic sclk_rise, cs_lvl, cs_rise, mosi_lvl;
  logic sclk_lvl_unused, sclk_fall_unused, cs_fall_unused, mosi_rise_unused, mosi_fall_unused;
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(bus.sclk),
    .lvl_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d_i(bus.cs),
    .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall_unused)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d_i(bus.mosi),
    .lvl_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );
  assign shift_d  = {mosi_lvl, shift_q[WIDTH-1:1]};
  assign bus.dout = dout_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = state_q == RECV;
  // Synchronise reset release: the FSM acts from the clk after rst is seen high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else run_q <= 1'b1;
  end
  // Frame FSM; a final bit landing together with cs rising still completes the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (run_q) begin
        case (state_q)
          IDLE: begin
            if (!cs_lvl) begin
              state_q <= RECV;
              cnt_q   <= '0;
            end
          end
          RECV: begin
            if (cnt_q == FULL) begin
              dout_q  <= shift_q;
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= cs_lvl ? IDLE : WAIT_CS;
            end else if (cs_rise && !(sclk_rise && cnt_q == LAST)) begin
              err_q   <= 1'b1;
              shift_q <= '0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else if (sclk_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          WAIT_CS: begin
            if (cs_rise) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: scoreboard bench for the SPI receiver at 12/2 and 8/3 configurations
module tb_spi_slave_rx;
  localparam int W = 12;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  spi_slave_rx_if #(.WIDTH(W)) b ();
  spi_slave_rx_if #(.WIDTH(8)) b8 ();
  spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(b));
  spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(3)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n8_done = 0;
  int n8_err = 0;
  logic [W:0] expq[$];
  logic [W-1:0] exp_dout = '0;
  time final_rise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every frame the bench sends queues the event it must produce
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst) begin
      check("rst_dout", 32'(b.dout), 0);
      check("rst_flags", {29'd0, b.done, b.err, b.busy}, 0);
      exp_dout = '0;
    end else begin
      check("done_err_excl", {31'd0, b.done & b.err}, 0);
      if (b.done) n_done++;
      if (b.err) n_err++;
      if (b.done || b.err) begin
        if (expq.size() == 0) check("unexpected_evt", {30'd0, b.done, b.err}, 0);
        else begin
          e = expq.pop_front();
          check("evt_kind", {31'd0, b.done}, {31'd0, e[W]});
          if (b.done) begin
            check("done_dout", 32'(b.dout), 32'(e[W-1:0]));
            check("done_latency", {31'd0, ($time - final_rise) <= 45}, 1);
            exp_dout = e[W-1:0];
          end
        end
      end
      if (!b.done) check("dout_hold", 32'(b.dout), 32'(exp_dout));
    end
  end

  // Event counters for the narrow instance
  always @(negedge clk) begin
    if (rst && b8.done) n8_done++;
    if (rst && b8.err) n8_err++;
  end

  task automatic send_bits(input logic [15:0] d, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      b.mosi = d[i];
      repeat (half) @(posedge clk);
      #1 b.sclk = 1'b1;
      if (i == W - 1) final_rise = $time;
      repeat (half) @(posedge clk);
      #1 b.sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] d, input int n);
    int k;
    expq.push_back(n >= W ? {1'b1, d[W-1:0]} : {1'b0, 12'h000});
    b.cs = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("busy_in_frame", {31'd0, b.busy}, 1);
    send_bits(d, n, 10);
    repeat (10) @(posedge clk);
    #1 b.cs = 1'b1;
    k = 0;
    while (expq.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    check("drain", expq.size(), 0);
    expq.delete();
    repeat (40) @(posedge clk);
    #1 check("busy_after", {31'd0, b.busy}, 0);
  endtask

  initial begin
    logic [7:0] w8;
    logic [7:0] d8;
    bit seen;
    int nd, ne;
    b.sclk = 1'b0; b.cs = 1'b1; b.mosi = 1'b0;
    b8.sclk = 1'b0; b8.cs = 1'b1; b8.mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    frame(16'h0ABC, 12);
    check("lit_abc", 32'(b.dout), 32'h0ABC);
    check("cnt_abc", n_done * 16 + n_err, 16);
    frame(16'h0001, 12);
    frame(16'h0800, 12);
    frame(16'h05A5, 12);
    check("lit_5a5", 32'(b.dout), 32'h05A5);
    check("cnt_b2b", n_done * 16 + n_err, 64);
    frame(16'h0123, 12);
    frame(16'h0FFF, 7);
    check("lit_abort_keep", 32'(b.dout), 32'h0123);
    check("cnt_abort", n_done * 16 + n_err, 81);
    frame(16'h0456, 12);
    check("lit_456", 32'(b.dout), 32'h0456);
    frame(16'h53C3, 15);
    check("lit_3c3", 32'(b.dout), 32'h03C3);
    check("cnt_junk", n_done * 16 + n_err, 113);
    nd = n_done;
    ne = n_err;
    b.cs = 1'b0;
    repeat (10) @(posedge clk);
    #1 send_bits(16'h002D, 6, 10);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("lit_rst_dout", 32'(b.dout), 0);
    b.cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("rst_no_evt", (n_done - nd) * 16 + (n_err - ne), 0);
    check("lit_after_rst", 32'(b.dout), 0);
    frame(16'h00F0, 12);
    check("lit_0f0", 32'(b.dout), 32'h00F0);
    w8 = 8'hC3;
    d8 = '0;
    seen = 1'b0;
    b8.cs = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 b8.mosi = w8[i];
      repeat (4) @(posedge clk);
      #1 b8.sclk = 1'b1;
      if (i == 7) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          if (b8.done && !seen) begin
            seen = 1'b1;
            d8 = b8.dout;
          end
        end
      end else repeat (4) @(posedge clk);
      #1 b8.sclk = 1'b0;
    end
    check("w8_latency", {31'd0, seen}, 1);
    check("w8_dout", 32'(d8), 32'h00C3);
    repeat (8) @(posedge clk);
    #1 b8.cs = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("w8_cnt", n8_done * 16 + n8_err, 16);
    check("w8_final", 32'(b8.dout), 32'h00C3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side endpoint for the `spi` master: samples `sclk`, `cs` and `mosi` in the local `clk` domain and deserialises one word per chip-select frame.
- Presents the word on `dout` with a one-cycle `done` strobe.
- Sits on the peripheral side of the link and feeds register or FIFO logic.
- Also serves as the scoreboard-side DUT partner when the master bench is run closed-loop.

Parameters:
- WIDTH, 12: bits per frame; matches the master `din` width.
- SYNC_STAGES, 2: flip-flop synchroniser depth on `sclk`, `cs` and `mosi`; legal values 2 or 3.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI serial clock from the master; asynchronous to `clk`; period ≥ 8 clk.
- cs  input  1  chip select, active-low; asynchronous.
- mosi  input  1  serial data, LSB first; stable around `sclk` rising edge.
- dout  output  WIDTH  last complete received word.
- done  output  1  one-clk pulse: `dout` updated this cycle.
- err  output  1  one-clk pulse: frame aborted (`cs` high before WIDTH bits).
- busy  output  1  high while a frame is being received.

Behaviour:
- Reset (`rst` low, async): `dout` = 0, `done` = 0, `err` = 0, `busy` = 0, state = IDLE, bit counter = 0, shift register = 0, synchroniser flops set to idle levels.
  - Idle levels: `sclk` = 0, `cs` = 1, `mosi` = 0.
  - Reset deassertion is synchronised internally; first active cycle is the clk after `rst` is seen high.
- Synchronisation:
  - `sclk`, `cs` and `mosi` each pass through SYNC_STAGES flops, so all three see equal delay.
  - One extra history flop per signal provides edge detection.
  - A pin transition is recognised at most SYNC_STAGES+1 clk later.
- Mode 0 only: data is captured on the `sclk` rising edge. Falling edges are ignored.
- State IDLE:
  - `busy` = 0.
  - Synchronised `cs` falling edge (or `cs` low on leaving reset) → RECV; bit counter cleared.
  - `sclk` edges while `cs` is high are ignored.
- State RECV:
  - `busy` = 1.
  - On each synchronised `sclk` rising edge: `shift <= {mosi_s, shift[WIDTH-1:1]}` (LSB-first fill); counter increments.
  - When the edge that brings the counter to WIDTH is detected, the next clk: `dout <= assembled word`, `done` = 1 for exactly one clk, state → WAIT_CS.
  - Synchronised `cs` rising edge with counter < WIDTH → `err` = 1 for one clk, `dout` unchanged, `shift` cleared, state → IDLE.
  - `cs` rising and the final `sclk` rising edge detected in the same clk: the bit is captured and the frame completes normally (`done`, no `err`), then → IDLE.
- State WAIT_CS:
  - `busy` = 0.
  - Further `sclk` edges are ignored (no overrun capture).
  - Synchronised `cs` rising → IDLE.
  - `cs` low-high-low pulses shorter than 1 clk after synchronisation are not guaranteed to register.
- Latency: `done` rises ≤ SYNC_STAGES+2 clk after the final `sclk` rising edge at the pin.
- Counter width: `$clog2(WIDTH+1)`; no wrap is possible because the counter stops at WIDTH.
- `done` and `err` are never asserted in the same cycle.
- Reset mid-frame: all state is discarded immediately and no `done` or `err` is emitted. The first frame after release requires a fresh `cs` fall, unless `cs` is already low, in which case bits are counted from the first rising `sclk` after release.

Decomposition:
- Package `spi_pkg`:
  - `typedef enum logic [1:0] {IDLE, RECV, WAIT_CS} spi_rx_state_t`
  - `localparam SPI_WIDTH_DEFAULT = 12`
  - Shared so the master and bench agree on frame width.
- Sub-module `spi_sync_edge`:
  - Parameter SYNC_STAGES, idle-level parameter.
  - Outputs: synchronised level, rise pulse, fall pulse.
  - Instantiated three times (`sclk`, `cs`, `mosi`; `mosi` uses the level output only).

Test Plan:
- Single frame, WIDTH=12, sclk = clk/20, master sends 12'hABC LSB first → exactly one `done` pulse; `dout` = 12'hABC; `err` never high; `busy` high from `cs` fall until `done`.
- Three back-to-back frames 12'h001, 12'h800, 12'h5A5, with `cs` high for 2 sclk periods between them → three `done` pulses with `dout` matching in order; no `err`.
- `cs` deasserted after 7 sclk rising edges of 12'hFFF, preceded by a completed 12'h123 → one `err` pulse, no `done`; `dout` stays 12'h123; the next full frame 12'h456 is received correctly.
- 15 sclk rising edges inside one `cs` frame carrying 12'h3C3 plus 3 junk bits → `done` once after bit 12 with `dout` = 12'h3C3; junk bits ignored.
- `rst` pulled low after 6 bits of a frame, released with `cs` high; then a full frame 12'h0F0 → no `done`/`err` from the aborted frame; `dout` reads 0 after reset, then 12'h0F0.
- Rebuild with WIDTH=8 and SYNC_STAGES=3, send 8'hC3 at sclk = clk/8 → `done` within 5 clk of the 8th sclk rise at the pin; `dout` = 8'hC3.
